alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
Parametrised, handshaked successor to the four-unit ALU. It provides a single decoded datapath with one merged result bus and a valid/ready input handshake. Most ops complete in one cycle. An iterative unsigned divider stalls the input for WIDTH+1 cycles. The block sits between the system controller (register file operands, ALU_FUN) and the result write-back / UART TX path.

Parameters:
WIDTH, 16, operand width in bits (>= 4).
SHAMT_W, $clog2(WIDTH), width of shift-amount field taken from B.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  synchronous active-low reset.
A  in  WIDTH  operand A (unsigned).
B  in  WIDTH  operand B (unsigned).
ALU_FUN  in  4  op code, sampled on accept.
IN_VALID  in  1  operands/op valid.
IN_READY  out  1  block can accept.
ALU_OUT  out  2*WIDTH  registered result.
OUT_VALID  out  1  one-cycle result strobe.
ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG  out  1 each  op class of current result; valid with OUT_VALID.
CARRY  out  1  ADD carry / SUB borrow.
ZERO  out  1  ALU_OUT == 0.
DIV_ERR  out  1  divide by zero.

Behaviour:
- Reset: RST sampled low at a CLK edge gives state IDLE. ALU_OUT=0, all flags=0, OUT_VALID=0, IN_READY=1 in the following cycle. Reset aborts any division in progress; no result is produced.
- Accept edge: rising edge with IN_VALID && IN_READY. A, B and ALU_FUN are captured there.
- Op codes (unsigned):
  - 0 ADD: {0, carry, sum}.
  - 1 SUB: A-B mod 2^WIDTH, CARRY = (A<B).
  - 2 MUL: full 2*WIDTH product.
  - 3 DIV: ALU_OUT = {remainder, quotient}.
  - 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR: zero-extended.
  - 10 EQ, 11 GT (A>B), 12 LT: 1 or 0.
  - 13 SHR: A >> B[SHAMT_W-1:0].
  - 14 SHL: A << B[SHAMT_W-1:0], zero-extended, no overflow kept.
  - 15 NOP.
- Flags by class: ARITH_FLAG for 0-3, LOGIC_FLAG for 4-9, CMP_FLAG for 10-12, SHIFT_FLAG for 13-14.
- FSM states: IDLE, DIV_RUN.
- IDLE: IN_READY=1.
  - Non-DIV accept: ALU_OUT and flags are registered at the accept edge. OUT_VALID is high for exactly the next cycle (latency 1, throughput 1 op/cycle, back-to-back supported).
  - NOP accept: OUT_VALID stays 0; ALU_OUT and flags hold.
  - DIV accept with B==0: latency 1, ALU_OUT = all ones, DIV_ERR=1, ARITH_FLAG=1, state stays IDLE.
  - DIV accept with B!=0: go to DIV_RUN, IN_READY=0, iteration counter = 0.
- DIV_RUN: restoring divider, one quotient bit per cycle, MSB first. After WIDTH iterations: result registered, OUT_VALID pulses, return to IDLE.
  - OUT_VALID rises WIDTH+1 edges after the accept edge.
  - IN_READY returns to 1 on that same edge.
  - IN_VALID during DIV_RUN is ignored.
- CARRY, ZERO and DIV_ERR update only with a new result. Each is 0 when it does not apply to the op.
- OUT_VALID has no backpressure; the consumer must accept it every cycle.

Optional Feature:
ALU_SEQ_MUL_EN
- Defined: op 2 instantiates a single-cycle WIDTH x WIDTH multiplier.
- Undefined: no multiplier is built. Op 2 is accepted with latency 1 and yields ALU_OUT=0, ARITH_FLAG=1, DIV_ERR=0, ZERO=1.

Decomposition:
- Package alu_seq_pkg: op-code localparams (ALU_ADD..ALU_NOP), FSM state encoding, flag-class constants.
- One sub-module: alu_seq_div. It is the iterative restoring divider with start/busy/done and quotient/remainder outputs, parametrised by WIDTH. The top holds the FSM, the combinational single-cycle ops, and the output register.

Test Plan:
- WIDTH=16, ADD A=16'hFFFF B=16'h0001 -> next cycle ALU_OUT=32'h0001_0000, CARRY=1, ZERO=0, ARITH_FLAG=1, OUT_VALID one cycle.
- DIV A=100 B=7 -> IN_READY low 17 cycles; ALU_OUT=32'h0002_000E, OUT_VALID at edge 17 after accept; concurrent IN_VALID ignored.
- DIV B=0 -> next cycle ALU_OUT=32'hFFFF_FFFF, DIV_ERR=1, state remains IDLE.
- Back-to-back XOR 16'hA5A5^16'h5A5A, GT 3>2, SHL 16'h0001 by 4 -> consecutive OUT_VALID with 32'h0000_FFFF (LOGIC), 1 (CMP), 32'h0000_0010 (SHIFT).
- RST low for one edge during DIV_RUN (iteration 5) -> no OUT_VALID, outputs 0, IN_READY=1 next cycle; a following ADD 2+3 gives 5.
- MUL 16'hFFFF*16'hFFFF -> 32'hFFFE_0001 with ALU_SEQ_MUL_EN; ALU_OUT=0, ZERO=1 without it.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM encoding and result-class flags for alu_seq_core.
// The op-class helper maps ALU_FUN onto the four class strobes.
package alu_seq_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_DIV  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_NAND = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_XNOR = 4'd9;
    localparam logic [3:0] ALU_EQ   = 4'd10;
    localparam logic [3:0] ALU_GT   = 4'd11;
    localparam logic [3:0] ALU_LT   = 4'd12;
    localparam logic [3:0] ALU_SHR  = 4'd13;
    localparam logic [3:0] ALU_SHL  = 4'd14;
    localparam logic [3:0] ALU_NOP  = 4'd15;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_DIV_RUN = 1'b1
    } state_t;

    typedef struct packed {
        logic arith;
        logic logc;
        logic cmp;
        logic shft;
    } cls_t;

    localparam cls_t CLS_NONE  = 4'b0000;
    localparam cls_t CLS_ARITH = 4'b1000;
    localparam cls_t CLS_LOGIC = 4'b0100;
    localparam cls_t CLS_CMP   = 4'b0010;
    localparam cls_t CLS_SHIFT = 4'b0001;

    function automatic cls_t op_class(input logic [3:0] op);
        cls_t c;
        case (op)
            ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV:                         c = CLS_ARITH;
            ALU_AND, ALU_OR, ALU_NAND, ALU_NOR, ALU_XOR, ALU_XNOR:      c = CLS_LOGIC;
            ALU_EQ, ALU_GT, ALU_LT:                                     c = CLS_CMP;
            ALU_SHR, ALU_SHL:                                           c = CLS_SHIFT;
            default:                                                    c = CLS_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/op request channel and registered result bus between the controller and the ALU.
// master = controller side, slave = ALU side.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [3:0]         ALU_FUN;
    logic               IN_VALID;
    logic               IN_READY;
    logic [2*WIDTH-1:0] ALU_OUT;
    logic               OUT_VALID;
    logic               ARITH_FLAG;
    logic               LOGIC_FLAG;
    logic               CMP_FLAG;
    logic               SHIFT_FLAG;
    logic               CARRY;
    logic               ZERO;
    logic               DIV_ERR;

    modport master (
        output A, B, ALU_FUN, IN_VALID,
        input  IN_READY, ALU_OUT, OUT_VALID, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG,
               SHIFT_FLAG, CARRY, ZERO, DIV_ERR
    );

    modport slave (
        input  A, B, ALU_FUN, IN_VALID,
        output IN_READY, ALU_OUT, OUT_VALID, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG,
               SHIFT_FLAG, CARRY, ZERO, DIV_ERR
    );
endinterface

// File: rtl/alu_seq_div.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB first.
// Latency: WIDTH cycles after start until done; start is ignored while busy.
module alu_seq_div #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_iter;

    // The dividend shifts out of r_quo MSB-first while quotient bits shift in.
    assign w_trial = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_dvs};
    assign w_iter  = r_busy && (r_cnt != CNT_W'(WIDTH));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_quo  <= i_dividend;
            r_rem  <= '0;
            r_dvs  <= i_divisor;
        end else if (w_iter) begin
            if (!w_diff[WIDTH]) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (o_done) begin
            r_busy <= 1'b0;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CNT_W'(WIDTH));
    assign o_quo  = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked single-datapath ALU with merged 2*WIDTH result; optional multiplier via ALU_SEQ_MUL_EN.
// Latency 1 for all ops except DIV (WIDTH+1 edges); throughput 1 op/cycle outside DIV.
// IN_READY drops while a division runs; OUT_VALID has no backpressure.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic      CLK,
    input  logic      RST,
    alu_seq_if.slave  bus
);
    state_t             r_state;
    state_t             w_state_nxt;

    logic [2*WIDTH-1:0] r_alu_out;
    logic               r_out_vld;
    cls_t               r_cls;
    logic               r_carry;
    logic               r_zero;
    logic               r_div_err;

    logic               w_in_rdy;
    logic               w_acc;
    logic               w_div_start;
    logic               w_div_fin;
    logic               w_div_busy;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_div_rem;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [SHAMT_W-1:0] w_shamt;
    logic [2*WIDTH-1:0] w_res;
    cls_t               w_cls;
    logic               w_carry;
    logic               w_div_err;

    logic               w_load;
    logic [2*WIDTH-1:0] w_nxt_res;
    cls_t               w_nxt_cls;
    logic               w_nxt_carry;
    logic               w_nxt_err;

    assign w_acc   = bus.IN_VALID && w_in_rdy;
    assign w_sum   = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_diff  = {1'b0, bus.A} - {1'b0, bus.B};
    assign w_shamt = bus.B[SHAMT_W-1:0];

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
`endif

    alu_seq_div #(.WIDTH(WIDTH)) u_div (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_start    (w_div_start),
        .i_dividend (bus.A),
        .i_divisor  (bus.B),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quo      (w_div_quo),
        .o_rem      (w_div_rem)
    );

    always_ff @(posedge CLK) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_div_start) w_state_nxt = ST_DIV_RUN;
            ST_DIV_RUN: if (w_div_fin)   w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_rdy    = (r_state == ST_IDLE);
        w_div_start = (r_state == ST_IDLE) && bus.IN_VALID &&
                      (bus.ALU_FUN == ALU_DIV) && (bus.B != '0);
        w_div_fin   = (r_state == ST_DIV_RUN) && w_div_busy && w_div_done;
    end

    // Single-cycle ops; DIV here only covers the divide-by-zero shortcut.
    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_div_err = 1'b0;
        w_cls     = op_class(bus.ALU_FUN);
        case (bus.ALU_FUN)
            ALU_ADD: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_sum};
                w_carry = w_sum[WIDTH];
            end
            ALU_SUB: begin
                w_res   = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                w_carry = w_diff[WIDTH];
            end
`ifdef ALU_SEQ_MUL_EN
            ALU_MUL:  w_res = w_prod;
`else
            ALU_MUL:  w_res = '0;
`endif
            ALU_DIV: begin
                w_res     = '1;
                w_div_err = 1'b1;
            end
            ALU_AND:  w_res = {{WIDTH{1'b0}}, bus.A & bus.B};
            ALU_OR:   w_res = {{WIDTH{1'b0}}, bus.A | bus.B};
            ALU_NAND: w_res = {{WIDTH{1'b0}}, ~(bus.A & bus.B)};
            ALU_NOR:  w_res = {{WIDTH{1'b0}}, ~(bus.A | bus.B)};
            ALU_XOR:  w_res = {{WIDTH{1'b0}}, bus.A ^ bus.B};
            ALU_XNOR: w_res = {{WIDTH{1'b0}}, ~(bus.A ^ bus.B)};
            ALU_EQ:   w_res = {{(2*WIDTH-1){1'b0}}, (bus.A == bus.B)};
            ALU_GT:   w_res = {{(2*WIDTH-1){1'b0}}, (bus.A >  bus.B)};
            ALU_LT:   w_res = {{(2*WIDTH-1){1'b0}}, (bus.A <  bus.B)};
            ALU_SHR:  w_res = {{WIDTH{1'b0}}, bus.A >> w_shamt};
            ALU_SHL:  w_res = {{WIDTH{1'b0}}, bus.A << w_shamt};
            default:  w_res = '0;
        endcase
    end

    always_comb begin
        w_load      = 1'b0;
        w_nxt_res   = w_res;
        w_nxt_cls   = w_cls;
        w_nxt_carry = w_carry;
        w_nxt_err   = w_div_err;
        if (w_div_fin) begin
            w_load      = 1'b1;
            w_nxt_res   = {w_div_rem, w_div_quo};
            w_nxt_cls   = CLS_ARITH;
            w_nxt_carry = 1'b0;
            w_nxt_err   = 1'b0;
        end else if (w_acc && (bus.ALU_FUN != ALU_NOP) && !w_div_start) begin
            w_load = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_alu_out <= '0;
            r_out_vld <= 1'b0;
            r_cls     <= CLS_NONE;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_div_err <= 1'b0;
        end else begin
            r_out_vld <= w_load;
            if (w_load) begin
                r_alu_out <= w_nxt_res;
                r_cls     <= w_nxt_cls;
                r_carry   <= w_nxt_carry;
                r_zero    <= (w_nxt_res == '0);
                r_div_err <= w_nxt_err;
            end
        end
    end

    assign bus.IN_READY   = w_in_rdy;
    assign bus.ALU_OUT    = r_alu_out;
    assign bus.OUT_VALID  = r_out_vld;
    assign bus.ARITH_FLAG = r_cls.arith;
    assign bus.LOGIC_FLAG = r_cls.logc;
    assign bus.CMP_FLAG   = r_cls.cmp;
    assign bus.SHIFT_FLAG = r_cls.shft;
    assign bus.CARRY      = r_carry;
    assign bus.ZERO       = r_zero;
    assign bus.DIV_ERR    = r_div_err;

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core at WIDTH=16: directed vectors push expectations,
// a negedge monitor pops and compares every OUT_VALID strobe including its arrival cycle.
module tb_alu_seq_core;
    import alu_seq_pkg::*;

    localparam int W = 16;
    localparam logic [3:0] C_A = 4'b1000;
    localparam logic [3:0] C_L = 4'b0100;
    localparam logic [3:0] C_C = 4'b0010;
    localparam logic [3:0] C_S = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_if #(.WIDTH(W)) bus();

    alu_seq_core #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2*W-1:0] res;
        logic [3:0]     cls;
        logic           carry;
        logic           zero;
        logic           err;
        int             cyc;
    } exp_t;

    exp_t  q[$];
    string qn[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (bus.OUT_VALID === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_out: got OUT_VALID with ALU_OUT=%0h, expected no result", bus.ALU_OUT);
            end else begin
                e  = q.pop_front();
                nm = qn.pop_front();
                chk({nm, ".res"},   bus.ALU_OUT, e.res);
                chk({nm, ".cls"},   {bus.ARITH_FLAG, bus.LOGIC_FLAG, bus.CMP_FLAG, bus.SHIFT_FLAG}, e.cls);
                chk({nm, ".carry"}, bus.CARRY, e.carry);
                chk({nm, ".zero"},  bus.ZERO, e.zero);
                chk({nm, ".err"},   bus.DIV_ERR, e.err);
                chk({nm, ".cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] res, input logic [3:0] cls, input logic carry,
                         input logic err, input int extra, input bit push, input string nm);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (bus.IN_READY !== 1'b1 && guard < 100) begin
            bus.IN_VALID = 1'b0;
            @(negedge clk);
            guard++;
        end
        if (bus.IN_READY !== 1'b1) chk({nm, ".ready_wait"}, bus.IN_READY, 1);
        bus.A        = a;
        bus.B        = b;
        bus.ALU_FUN  = op;
        bus.IN_VALID = 1'b1;
        if (push) begin
            e.res   = res;
            e.cls   = cls;
            e.carry = carry;
            e.zero  = (res == '0);
            e.err   = err;
            e.cyc   = cyc + 1 + extra;
            q.push_back(e);
            qn.push_back(nm);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.IN_VALID = 1'b0;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, ".alu_out"},   bus.ALU_OUT, 0);
        chk({nm, ".out_valid"}, bus.OUT_VALID, 0);
        chk({nm, ".in_ready"},  bus.IN_READY, 1);
        chk({nm, ".flags"},     {bus.ARITH_FLAG, bus.LOGIC_FLAG, bus.CMP_FLAG, bus.SHIFT_FLAG,
                                 bus.CARRY, bus.ZERO, bus.DIV_ERR}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    initial begin
        int lowcnt;
        int guard;
        bus.A = '0;
        bus.B = '0;
        bus.ALU_FUN = ALU_NOP;
        bus.IN_VALID = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b1;

        issue(ALU_ADD, 16'hFFFF, 16'h0001, 32'h0001_0000, C_A, 1, 0, 0, 1, "add_carry");
        issue(ALU_SUB, 16'h0003, 16'h0005, 32'h0000_FFFE, C_A, 1, 0, 0, 1, "sub_borrow");
        issue(ALU_SUB, 16'h0009, 16'h0004, 32'h0000_0005, C_A, 0, 0, 0, 1, "sub_plain");

        // DIV 100/7 with junk requests offered while stalled
        issue(ALU_DIV, 16'd100, 16'd7, 32'h0002_000E, C_A, 0, 0, W + 1, 1, "div_100_7");
        lowcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.IN_READY !== 1'b0) break;
            lowcnt++;
            bus.ALU_FUN  = ALU_ADD;
            bus.A        = 16'h0001;
            bus.B        = 16'h0001;
            bus.IN_VALID = 1'b1;
        end
        bus.IN_VALID = 1'b0;
        chk("div_stall_cycles", lowcnt, W + 1);

        issue(ALU_DIV, 16'd1234, 16'd0, 32'hFFFF_FFFF, C_A, 0, 1, 0, 1, "div_by_zero");
        issue(ALU_ADD, 16'h0000, 16'h0000, 32'h0000_0000, C_A, 0, 0, 0, 1, "add_after_dbz");

        issue(ALU_XOR, 16'hA5A5, 16'h5A5A, 32'h0000_FFFF, C_L, 0, 0, 0, 1, "xor");
        issue(ALU_GT,  16'h0003, 16'h0002, 32'h0000_0001, C_C, 0, 0, 0, 1, "gt");
        issue(ALU_SHL, 16'h0001, 16'h0004, 32'h0000_0010, C_S, 0, 0, 0, 1, "shl");
        issue(ALU_NOP, 16'h1234, 16'h5678, 32'h0, 4'b0, 0, 0, 0, 0, "nop");
        idle();
        chk("nop_hold.out_valid", bus.OUT_VALID, 0);
        chk("nop_hold.alu_out",   bus.ALU_OUT, 32'h0000_0010);
        chk("nop_hold.shift",     bus.SHIFT_FLAG, 1);

`ifdef ALU_SEQ_MUL_EN
        issue(ALU_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, C_A, 0, 0, 0, 1, "mul");
`else
        issue(ALU_MUL, 16'hFFFF, 16'hFFFF, 32'h0000_0000, C_A, 0, 0, 0, 1, "mul_off");
`endif
        issue(ALU_EQ,   16'h0005, 16'h0005, 32'h0000_0001, C_C, 0, 0, 0, 1, "eq");
        issue(ALU_LT,   16'h0002, 16'h0003, 32'h0000_0001, C_C, 0, 0, 0, 1, "lt");
        issue(ALU_LT,   16'h0003, 16'h0003, 32'h0000_0000, C_C, 0, 0, 0, 1, "lt_equal");
        issue(ALU_AND,  16'hF0F0, 16'h0F0F, 32'h0000_0000, C_L, 0, 0, 0, 1, "and_zero");
        issue(ALU_OR,   16'h00F0, 16'h0F00, 32'h0000_0FF0, C_L, 0, 0, 0, 1, "or");
        issue(ALU_NAND, 16'hFFFF, 16'hFFFF, 32'h0000_0000, C_L, 0, 0, 0, 1, "nand");
        issue(ALU_NOR,  16'h0000, 16'h0000, 32'h0000_FFFF, C_L, 0, 0, 0, 1, "nor");
        issue(ALU_XNOR, 16'h00FF, 16'h0F0F, 32'h0000_F00F, C_L, 0, 0, 0, 1, "xnor");
        issue(ALU_SHR,  16'h8000, 16'h000F, 32'h0000_0001, C_S, 0, 0, 0, 1, "shr_max");
        issue(ALU_SHL,  16'h8001, 16'h0011, 32'h0000_0002, C_S, 0, 0, 0, 1, "shl_wrap_amt");

        // Reset lands a few iterations into a division; nothing may come out
        issue(ALU_DIV, 16'd1000, 16'd3, 32'h0, 4'b0, 0, 0, 0, 0, "div_abort");
        idle();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("abort");
        rst = 1'b1;
        repeat (25) @(negedge clk);
        issue(ALU_ADD, 16'h0002, 16'h0003, 32'h0000_0005, C_A, 0, 0, 0, 1, "add_after_rst");
        idle();

        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("queue_drained", q.size(), 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
